// File: rtl/uart_pkg.sv
// Shared UART constants: TX state encodings, parity types and line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_typ_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/parity_calc.sv
// Computes and holds the frame parity bit, captured once when a word is accepted.
module parity_calc
  import uart_pkg::*;
#(
  parameter int unsigned width = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [width-1:0] Data,
  input  logic             PAR_TYP,
  input  logic             load,
  output logic             parity
);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      parity <= 1'b0;
    end else if (load) begin
      parity <= (PAR_TYP == PAR_ODD) ? ~^Data : ^Data;
    end
  end

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmit sequencer: start, width data bits from the serializer, optional parity, stop.
module uart_tx_fsm
  import uart_pkg::*;
#(
  parameter int unsigned width = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [width-1:0] Data,
  input  logic             Data_valid,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  input  logic             Ser_data,
  output logic             Ser_EN,
  output logic             Busy,
  output logic             TX_OUT
);

  localparam int unsigned      CNT_W    = (width > 1) ? $clog2(width) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(width - 1);

  tx_state_e        state, state_next;
  logic [CNT_W-1:0] cnt_q, cnt_next;
  logic             par_en_q, par_en_next;
  logic             load;
  logic             parity;

  parity_calc #(.width(width)) u_parity (
    .CLK     (CLK),
    .Reset   (Reset),
    .Data    (Data),
    .PAR_TYP (PAR_TYP),
    .load    (load),
    .parity  (parity)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state    <= ST_IDLE;
      cnt_q    <= '0;
      par_en_q <= 1'b0;
    end else begin
      state    <= state_next;
      cnt_q    <= cnt_next;
      par_en_q <= par_en_next;
    end
  end

  // Acceptance is only possible in IDLE and STOP, where Busy is low.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt_q;
    par_en_next = par_en_q;
    load        = 1'b0;
    Busy        = 1'b0;
    Ser_EN      = 1'b0;
    TX_OUT      = LINE_IDLE;
    case (state)
      ST_IDLE: begin
        if (Data_valid) begin
          load       = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        Busy       = 1'b1;
        TX_OUT     = LINE_START;
        cnt_next   = '0;
        state_next = ST_DATA;
      end
      ST_DATA: begin
        Busy   = 1'b1;
        Ser_EN = 1'b1;
        TX_OUT = Ser_data;
        if (cnt_q == LAST_BIT) begin
          state_next = par_en_q ? ST_PARITY : ST_STOP;
        end else begin
          cnt_next = cnt_q + CNT_W'(1);
        end
      end
      ST_PARITY: begin
        Busy       = 1'b1;
        TX_OUT     = parity;
        state_next = ST_STOP;
      end
      ST_STOP: begin
        TX_OUT = LINE_STOP;
        if (Data_valid) begin
          load       = 1'b1;
          state_next = ST_START;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (load) par_en_next = PAR_EN;
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed bench for uart_tx_fsm at width 8 and width 7, with a behavioural serializer per instance.
module tb_uart_tx_fsm;

  logic       CLK = 1'b0;
  logic       Reset;
  logic       par_en, par_typ;
  logic [7:0] data8;
  logic       valid8, ser8, sen8, busy8, tx8;
  logic [6:0] data7;
  logic       valid7, ser7, sen7, busy7, tx7;
  logic [7:0] sh8;
  logic [6:0] sh7;
  logic       sel7;
  logic       cur_tx, cur_busy, cur_sen;
  int         n_cmp, n_bad;

  always #5 CLK = ~CLK;

  uart_tx_fsm #(.width(8)) u_dut8 (
    .CLK(CLK), .Reset(Reset), .Data(data8), .Data_valid(valid8),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .Ser_data(ser8),
    .Ser_EN(sen8), .Busy(busy8), .TX_OUT(tx8)
  );

  uart_tx_fsm #(.width(7)) u_dut7 (
    .CLK(CLK), .Reset(Reset), .Data(data7), .Data_valid(valid7),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .Ser_data(ser7),
    .Ser_EN(sen7), .Busy(busy7), .TX_OUT(tx7)
  );

  // Serializers load on the same acceptance edge as the FSM and shift LSB first.
  always @(posedge CLK or negedge Reset) begin
    if (!Reset) sh8 <= '0;
    else if (valid8 && !busy8) sh8 <= data8;
    else if (sen8) sh8 <= sh8 >> 1;
  end

  always @(posedge CLK or negedge Reset) begin
    if (!Reset) sh7 <= '0;
    else if (valid7 && !busy7) sh7 <= data7;
    else if (sen7) sh7 <= sh7 >> 1;
  end

  assign ser8     = sh8[0];
  assign ser7     = sh7[0];
  assign cur_tx   = sel7 ? tx7   : tx8;
  assign cur_busy = sel7 ? busy7 : busy8;
  assign cur_sen  = sel7 ? sen7  : sen8;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle(input string name);
    check({name, " idle tx"},   32'(cur_tx),   32'd1);
    check({name, " idle busy"}, 32'(cur_busy), 32'd0);
    check({name, " idle sen"},  32'(cur_sen),  32'd0);
  endtask

  task automatic accept8(input logic [7:0] d, input logic pe, input logic pt);
    data8   = d;
    par_en  = pe;
    par_typ = pt;
    valid8  = 1'b1;
    tick();
    valid8  = 1'b0;
  endtask

  // Expected vectors are written in line order: bit n-1 is the START slot.
  task automatic run_frame(input string name, input int n, input logic [10:0] etx,
                           input logic [10:0] ebusy, input logic [10:0] esen,
                           input int sen_exp, input bit disturb);
    int sen_cnt;
    sen_cnt = 0;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s tx[%0d]", name, i),   32'(cur_tx),   32'(etx[n-1-i]));
      check($sformatf("%s busy[%0d]", name, i), 32'(cur_busy), 32'(ebusy[n-1-i]));
      check($sformatf("%s sen[%0d]", name, i),  32'(cur_sen),  32'(esen[n-1-i]));
      if (cur_sen) sen_cnt++;
      if (disturb && i == 3) begin
        data8   = ~data8;
        par_en  = ~par_en;
        par_typ = ~par_typ;
        valid8  = 1'b1;
      end
      if (disturb && i == 4) valid8 = 1'b0;
      tick();
    end
    check({name, " sen count"}, 32'(sen_cnt), 32'(sen_exp));
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    Reset   = 1'b0;
    data8   = '0;
    valid8  = 1'b0;
    data7   = '0;
    valid7  = 1'b0;
    par_en  = 1'b0;
    par_typ = 1'b0;
    sel7    = 1'b0;

    #1;
    check_idle("reset");
    repeat (2) tick();
    Reset = 1'b1;
    tick();
    check_idle("post_reset");

    accept8(8'hA5, 1'b1, 1'b0);
    run_frame("a5_even", 11, 11'b01010010101, 11'b11111111110, 11'b01111111100, 8, 1'b0);
    check_idle("a5_even");

    accept8(8'hA5, 1'b1, 1'b1);
    run_frame("a5_odd", 11, 11'b01010010111, 11'b11111111110, 11'b01111111100, 8, 1'b0);
    check_idle("a5_odd");

    accept8(8'hA5, 1'b0, 1'b0);
    run_frame("a5_nopar", 10, 11'b0101001011, 11'b1111111110, 11'b0111111110, 8, 1'b0);
    check_idle("a5_nopar");

    data8   = 8'h3C;
    par_en  = 1'b1;
    par_typ = 1'b0;
    valid8  = 1'b1;
    tick();
    data8   = 8'hFF;
    run_frame("b2b_3c", 11, 11'b00011110001, 11'b11111111110, 11'b01111111100, 8, 1'b0);
    valid8  = 1'b0;
    run_frame("b2b_ff", 11, 11'b01111111101, 11'b11111111110, 11'b01111111100, 8, 1'b0);
    check_idle("b2b");
    tick();
    check_idle("b2b_hold");

    accept8(8'hA5, 1'b1, 1'b0);
    run_frame("disturb", 11, 11'b01010010101, 11'b11111111110, 11'b01111111100, 8, 1'b1);
    check_idle("disturb");

    // Reset lands mid-cycle in the 4th DATA slot, where the line carries a 0.
    accept8(8'hA5, 1'b1, 1'b0);
    repeat (4) tick();
    check("pre_reset tx", 32'(tx8), 32'd0);
    #2 Reset = 1'b0;
    #1;
    check("async_reset tx",   32'(tx8),   32'd1);
    check("async_reset busy", 32'(busy8), 32'd0);
    check("async_reset sen",  32'(sen8),  32'd0);
    #2 Reset = 1'b1;
    tick();
    check_idle("after_reset");
    accept8(8'h55, 1'b1, 1'b0);
    run_frame("post_reset_55", 11, 11'b01010101001, 11'b11111111110, 11'b01111111100, 8, 1'b0);
    check_idle("post_reset_55");

    sel7    = 1'b1;
    data7   = 7'h41;
    par_en  = 1'b1;
    par_typ = 1'b0;
    valid7  = 1'b1;
    tick();
    valid7  = 1'b0;
    run_frame("w7_41", 10, 11'b0100000101, 11'b1111111110, 11'b0111111100, 7, 1'b0);
    check_idle("w7_41");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
